// File: rtl/fft64_ctrl_if.sv
// Handshake and bus bundle between the 64-point FFT controller and its
// surroundings: input loading, core issue, writeback and output unloading.
interface fft64_ctrl_if;
  logic        start_i;
  logic        in_vld_i;
  logic        in_rdy_o;
  logic        buf_wr_en_o;
  logic [5:0]  buf_wr_addr_o;
  logic        grp_vld_o;
  logic [5:0]  grp_base_o;
  logic        grp_stride8_o;
  logic        tw_en_o;
  logic [47:0] tw_exp_o;
  logic        wb_vld_o;
  logic [5:0]  wb_base_o;
  logic        wb_stride8_o;
  logic        out_vld_o;
  logic        out_rdy_i;
  logic [5:0]  out_addr_o;
  logic        busy_o;
  logic        done_o;

  modport master (
    output start_i, in_vld_i, out_rdy_i,
    input  in_rdy_o, buf_wr_en_o, buf_wr_addr_o, grp_vld_o, grp_base_o,
           grp_stride8_o, tw_en_o, tw_exp_o, wb_vld_o, wb_base_o,
           wb_stride8_o, out_vld_o, out_addr_o, busy_o, done_o
  );

  modport slave (
    input  start_i, in_vld_i, out_rdy_i,
    output in_rdy_o, buf_wr_en_o, buf_wr_addr_o, grp_vld_o, grp_base_o,
           grp_stride8_o, tw_en_o, tw_exp_o, wb_vld_o, wb_base_o,
           wb_stride8_o, out_vld_o, out_addr_o, busy_o, done_o
  );
endinterface

// File: rtl/fft64_ctrl.sv
// Controller for a 64-point radix-8 FFT built on one shared 8-point core.
// Loads 64 samples, runs two passes of eight 8-point groups (first pass
// stride 8 with twiddles, second pass stride 1), tracks the core latency
// with a shift pipeline for writebacks, then unloads in digit-reversed
// buffer order so the samples leave in natural order.
module fft64_ctrl #(
  parameter int CORE_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  fft64_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    S1,
    S1_DRAIN,
    S2,
    S2_DRAIN,
    UNLOAD
  } state_t;

  localparam int          PIPE_W   = 8 * CORE_LAT;
  localparam logic [5:0]  LAT_LAST = 6'(CORE_LAT - 1);

  state_t             state;
  state_t             state_next;
  logic [5:0]         cnt;
  logic [5:0]         cnt_next;
  logic [PIPE_W-1:0]  wb_pipe;
  logic [7:0]         wb_stage_in;
  logic [7:0]         wb_stage_out;

  // State and counter register; reset aborts any transform in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 6'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and counter sequencing through load, two passes and unload.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (bus.start_i) begin
          state_next = LOAD;
          cnt_next   = 6'd0;
        end
      end
      LOAD: begin
        if (bus.in_vld_i) begin
          if (cnt == 6'd63) begin
            state_next = S1;
            cnt_next   = 6'd0;
          end else begin
            cnt_next = cnt + 6'd1;
          end
        end
      end
      S1: begin
        if (cnt[2:0] == 3'd7) begin
          state_next = S1_DRAIN;
          cnt_next   = 6'd0;
        end else begin
          cnt_next = cnt + 6'd1;
        end
      end
      S1_DRAIN: begin
        if (cnt == LAT_LAST) begin
          state_next = S2;
          cnt_next   = 6'd0;
        end else begin
          cnt_next = cnt + 6'd1;
        end
      end
      S2: begin
        if (cnt[2:0] == 3'd7) begin
          state_next = S2_DRAIN;
          cnt_next   = 6'd0;
        end else begin
          cnt_next = cnt + 6'd1;
        end
      end
      S2_DRAIN: begin
        if (cnt == LAT_LAST) begin
          state_next = UNLOAD;
          cnt_next   = 6'd0;
        end else begin
          cnt_next = cnt + 6'd1;
        end
      end
      UNLOAD: begin
        if (bus.out_rdy_i) begin
          if (cnt == 6'd63) begin
            state_next = IDLE;
            cnt_next   = 6'd0;
          end else begin
            cnt_next = cnt + 6'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 6'd0;
      end
    endcase
  end

  // Per-state strobes and addresses; every field is zero when its strobe is low.
  always_comb begin
    bus.in_rdy_o      = 1'b0;
    bus.buf_wr_en_o   = 1'b0;
    bus.buf_wr_addr_o = 6'd0;
    bus.grp_vld_o     = 1'b0;
    bus.grp_base_o    = 6'd0;
    bus.grp_stride8_o = 1'b0;
    bus.tw_en_o       = 1'b0;
    bus.tw_exp_o      = 48'd0;
    bus.out_vld_o     = 1'b0;
    bus.out_addr_o    = 6'd0;
    bus.busy_o        = (state != IDLE);
    bus.done_o        = 1'b0;
    case (state)
      LOAD: begin
        bus.in_rdy_o = 1'b1;
        if (bus.in_vld_i) begin
          bus.buf_wr_en_o   = 1'b1;
          bus.buf_wr_addr_o = cnt;
        end
      end
      S1: begin
        bus.grp_vld_o     = 1'b1;
        bus.grp_base_o    = {3'd0, cnt[2:0]};
        bus.grp_stride8_o = 1'b1;
        bus.tw_en_o       = 1'b1;
        for (int k = 0; k < 8; k++) begin
          bus.tw_exp_o[6*k +: 6] = 6'(cnt[2:0]) * 6'(k);
        end
      end
      S2: begin
        bus.grp_vld_o  = 1'b1;
        bus.grp_base_o = {cnt[2:0], 3'd0};
      end
      UNLOAD: begin
        bus.out_vld_o  = 1'b1;
        bus.out_addr_o = {cnt[2:0], cnt[5:3]};
        bus.done_o     = bus.out_rdy_i && (cnt == 6'd63);
      end
      default: begin
      end
    endcase
  end

  assign wb_stage_in  = {bus.grp_vld_o, bus.grp_stride8_o, bus.grp_base_o};
  assign wb_stage_out = wb_pipe[PIPE_W-1 -: 8];

  // Writeback shift pipeline: each issue reappears CORE_LAT cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_pipe <= '0;
    end else begin
      wb_pipe <= PIPE_W'({wb_pipe, wb_stage_in});
    end
  end

  assign bus.wb_vld_o     = wb_stage_out[7];
  assign bus.wb_stride8_o = wb_stage_out[6];
  assign bus.wb_base_o    = wb_stage_out[5:0];

endmodule

// File: tb/tb_fft64_ctrl.sv
// Directed bench for fft64_ctrl: full run, twiddle values, gapped flow,
// ignored start/valid, mid-pass reset, plus CORE_LAT=1 and 7 instances.
module tb_fft64_ctrl;

  logic clk;
  logic rst;
  logic start;
  logic in_vld;
  logic out_rdy;

  int cyc = 0;
  int check_cnt = 0;
  int err_cnt = 0;

  int wr_log[$];
  int s1_log[$];
  int s2_log[$];
  int out_log[$];
  int wb_base_log[$];
  int wb_stride_log[$];
  int grp_cyc[$];
  int wb_cyc[$];
  int done_cnt;
  int done_cyc;
  int start_cyc;
  int tw5_seen;
  int zero_bad;
  int hold_seen;
  logic stall_prev;
  logic [5:0] stall_addr;

  int wbn[3];
  int last_s1wb[3];
  int first_s2grp[3];

  fft64_ctrl_if bus2();
  fft64_ctrl_if bus1();
  fft64_ctrl_if bus7();

  assign bus2.start_i   = start;
  assign bus2.in_vld_i  = in_vld;
  assign bus2.out_rdy_i = out_rdy;
  assign bus1.start_i   = start;
  assign bus1.in_vld_i  = in_vld;
  assign bus1.out_rdy_i = out_rdy;
  assign bus7.start_i   = start;
  assign bus7.in_vld_i  = in_vld;
  assign bus7.out_rdy_i = out_rdy;

  fft64_ctrl #(.CORE_LAT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
  fft64_ctrl #(.CORE_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  fft64_ctrl #(.CORE_LAT(7)) u_dut7 (.clk(clk), .rst(rst), .bus(bus7.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle index shared by driver and monitor.
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    check_cnt++;
    if (observed !== expected) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic clearLogs();
    wr_log.delete();
    s1_log.delete();
    s2_log.delete();
    out_log.delete();
    wb_base_log.delete();
    wb_stride_log.delete();
    grp_cyc.delete();
    wb_cyc.delete();
    done_cnt   = 0;
    done_cyc   = 0;
    tw5_seen   = 0;
    zero_bad   = 0;
    hold_seen  = 0;
    stall_prev = 1'b0;
    stall_addr = 6'd0;
    for (int i = 0; i < 3; i++) begin
      wbn[i]         = 0;
      last_s1wb[i]   = -1;
      first_s2grp[i] = 1 << 30;
    end
  endtask

  task automatic recordLat(input int idx, input logic gv, input logic gs, input logic wv, input logic ws);
    if (wv) begin
      wbn[idx]++;
      if (ws) last_s1wb[idx] = cyc;
    end
    if (gv && !gs && first_s2grp[idx] > cyc) first_s2grp[idx] = cyc;
  endtask

  // Monitor sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus2.buf_wr_en_o) wr_log.push_back(int'(bus2.buf_wr_addr_o));
      if (bus2.grp_vld_o) begin
        grp_cyc.push_back(cyc);
        if (bus2.grp_stride8_o) s1_log.push_back(int'(bus2.grp_base_o));
        else s2_log.push_back(int'(bus2.grp_base_o));
        if (bus2.grp_stride8_o && bus2.grp_base_o == 6'd5) begin
          tw5_seen++;
          checkOutput("tw_g5_lane7", bus2.tw_exp_o[47:42], 35);
          checkOutput("tw_g5_lane0", bus2.tw_exp_o[5:0], 0);
          checkOutput("tw_g5_lane3", bus2.tw_exp_o[23:18], 15);
        end
        if (!bus2.grp_stride8_o && (bus2.tw_en_o || bus2.tw_exp_o != 48'd0)) zero_bad++;
      end
      if (bus2.wb_vld_o) begin
        wb_cyc.push_back(cyc);
        wb_base_log.push_back(int'(bus2.wb_base_o));
        wb_stride_log.push_back(int'(bus2.wb_stride8_o));
      end
      if (!bus2.grp_vld_o && (bus2.grp_base_o != 6'd0 || bus2.grp_stride8_o || bus2.tw_en_o)) zero_bad++;
      if (!bus2.tw_en_o && bus2.tw_exp_o != 48'd0) zero_bad++;
      if (!bus2.wb_vld_o && (bus2.wb_base_o != 6'd0 || bus2.wb_stride8_o)) zero_bad++;
      if (!bus2.buf_wr_en_o && bus2.buf_wr_addr_o != 6'd0) zero_bad++;
      if (!bus2.out_vld_o && bus2.out_addr_o != 6'd0) zero_bad++;
      if (bus2.buf_wr_en_o && bus2.out_vld_o) zero_bad++;
      if (stall_prev) begin
        hold_seen++;
        checkOutput("out_hold", bus2.out_vld_o ? int'(bus2.out_addr_o) : 99, int'(stall_addr));
      end
      if (bus2.out_vld_o && out_rdy) out_log.push_back(int'(bus2.out_addr_o));
      stall_prev = bus2.out_vld_o && !out_rdy;
      stall_addr = bus2.out_addr_o;
      if (bus2.done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      recordLat(0, bus2.grp_vld_o, bus2.grp_stride8_o, bus2.wb_vld_o, bus2.wb_stride8_o);
      recordLat(1, bus1.grp_vld_o, bus1.grp_stride8_o, bus1.wb_vld_o, bus1.wb_stride8_o);
      recordLat(2, bus7.grp_vld_o, bus7.grp_stride8_o, bus7.wb_vld_o, bus7.wb_stride8_o);
    end
  end

  // mode 0: continuous flow; 1: gapped input and output; 2: start during S2, valid during unload
  task automatic applyStimulus(input int mode);
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 2000 && done_cnt == 0; n++) begin
      case (mode)
        0: begin
          in_vld  = (n < 64);
          out_rdy = 1'b1;
        end
        1: begin
          in_vld  = (n % 2 == 0);
          out_rdy = (n % 3 != 2);
        end
        default: begin
          in_vld  = 1'b1;
          out_rdy = 1'b1;
          if (bus2.grp_vld_o && !bus2.grp_stride8_o) start = 1'b1;
        end
      endcase
      @(posedge clk); #1;
    end
    start   = 1'b0;
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    checkOutput("done_seen", done_cnt, 1);
    repeat (40) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic checkRun(input bit exact);
    checkOutput("wr_count", wr_log.size(), 64);
    for (int i = 0; i < 64; i++)
      if (i < wr_log.size()) checkOutput($sformatf("wr_addr[%0d]", i), wr_log[i], i);
    checkOutput("s1_count", s1_log.size(), 8);
    checkOutput("s2_count", s2_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < s1_log.size()) checkOutput($sformatf("s1_base[%0d]", i), s1_log[i], i);
      if (i < s2_log.size()) checkOutput($sformatf("s2_base[%0d]", i), s2_log[i], 8 * i);
    end
    checkOutput("out_count", out_log.size(), 64);
    for (int i = 0; i < 64; i++)
      if (i < out_log.size()) checkOutput($sformatf("out_addr[%0d]", i), out_log[i], (i % 8) * 8 + i / 8);
    checkOutput("wb_count", wb_cyc.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < wb_cyc.size() && i < grp_cyc.size()) begin
        checkOutput($sformatf("wb_base[%0d]", i), wb_base_log[i], (i < 8) ? i : 8 * (i - 8));
        checkOutput($sformatf("wb_stride[%0d]", i), wb_stride_log[i], (i < 8) ? 1 : 0);
        checkOutput($sformatf("wb_lat[%0d]", i), wb_cyc[i] - grp_cyc[i], 2);
      end
    end
    checkOutput("done_count", done_cnt, 1);
    if (exact) checkOutput("run_cycles", done_cyc - start_cyc + 1, 1 + 64 + 16 + 2 * 2 + 64);
    checkOutput("tw_g5_seen", tw5_seen, 1);
    checkOutput("strobe_zero", zero_bad, 0);
    checkOutput("idle_busy", bus2.busy_o, 0);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    in_vld  = 1'b0;
    out_rdy = 1'b0;
    clearLogs();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_outputs", {bus2.in_rdy_o, bus2.buf_wr_en_o, bus2.buf_wr_addr_o, bus2.grp_vld_o,
                                bus2.grp_base_o, bus2.grp_stride8_o, bus2.tw_en_o, bus2.wb_vld_o,
                                bus2.wb_base_o, bus2.wb_stride8_o, bus2.out_vld_o, bus2.out_addr_o,
                                bus2.busy_o, bus2.done_o}, 0);
    checkOutput("rst_tw_exp", bus2.tw_exp_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Full run, first start after reset, all three latencies in parallel
    $display("[TB] full run");
    clearLogs();
    applyStimulus(0);
    checkRun(1'b1);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("lat%0d_wb_pulses", i), wbn[i], 16);
      checkOutput($sformatf("lat%0d_drain_order", i), (last_s1wb[i] < first_s2grp[i]) ? 1 : 0, 1);
    end

    // Gapped input and output
    $display("[TB] gapped run");
    clearLogs();
    applyStimulus(1);
    checkRun(1'b0);
    checkOutput("stalls_seen", (hold_seen > 0) ? 1 : 0, 1);

    // start during S2 and in_vld during UNLOAD are ignored
    $display("[TB] ignored start/valid run");
    clearLogs();
    applyStimulus(2);
    checkRun(1'b1);

    // Reset after three S1 issues
    $display("[TB] reset in S1");
    clearLogs();
    start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    in_vld = 1'b1;
    repeat (64) begin
      @(posedge clk); #1;
    end
    in_vld = 1'b0;
    for (int n = 0; n < 50 && s1_log.size() < 3; n++) begin
      @(posedge clk); #1;
    end
    checkOutput("s1_issues_before_rst", s1_log.size(), 3);
    rst = 1'b1;
    #1;
    checkOutput("midrst_outputs", {bus2.in_rdy_o, bus2.buf_wr_en_o, bus2.buf_wr_addr_o, bus2.grp_vld_o,
                                   bus2.grp_base_o, bus2.grp_stride8_o, bus2.tw_en_o, bus2.wb_vld_o,
                                   bus2.wb_base_o, bus2.wb_stride8_o, bus2.out_vld_o, bus2.out_addr_o,
                                   bus2.busy_o, bus2.done_o}, 0);
    checkOutput("midrst_tw_exp", bus2.tw_exp_o, 0);
    clearLogs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
    end
    checkOutput("post_rst_wb", wb_cyc.size(), 0);
    checkOutput("post_rst_done", done_cnt, 0);
    checkOutput("post_rst_busy", bus2.busy_o, 0);
    clearLogs();
    applyStimulus(0);
    checkRun(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
